// File: rtl/team_06_wb_pkg.sv
// -----------------------------------------------------------------------------
// team_06_wb_pkg
// Shared types and constants for the Wishbone address decoder.
//   WB_ADDR_W / WB_DATA_W  bus widths
//   WB_SEL_W               byte-select width
//   DEC_ERR_DATA           read data returned alongside a bus error
//   WAIT_CNT_W             width of the slave-wait counter
//   dec_state_e            decoder FSM state encoding
//   idx_width()            channel index width for a given channel count
// -----------------------------------------------------------------------------
package team_06_wb_pkg;

    localparam int WB_ADDR_W  = 32;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = WB_DATA_W / 8;
    localparam int WAIT_CNT_W = 8;

    localparam logic [WB_DATA_W-1:0] DEC_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } dec_state_e;

    // A single channel still needs a 1-bit index so the select register exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/team_06_wb_addr_match.sv
// -----------------------------------------------------------------------------
// team_06_wb_addr_match
// Purely combinational address decode. A channel matches when the masked
// address equals its base; if several match, the lowest index wins.
// Ports:
//   adr    in   WB_ADDR_W              address to decode
//   bases  in   NUM_SLAVES*WB_ADDR_W   packed base addresses, channel 0 in LSBs
//   masks  in   NUM_SLAVES*WB_ADDR_W   packed compare masks, channel 0 in LSBs
//   hit    out  1                      at least one channel matched
//   idx    out  IDX_W                  index of the winning channel (0 if no hit)
// -----------------------------------------------------------------------------
module team_06_wb_addr_match
    import team_06_wb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [WB_ADDR_W-1:0]            adr,
    input  logic [NUM_SLAVES*WB_ADDR_W-1:0] bases,
    input  logic [NUM_SLAVES*WB_ADDR_W-1:0] masks,
    output logic                            hit,
    output logic [IDX_W-1:0]                idx
);

    // Walk from the highest channel down so the lowest matching index is
    // the last one written and therefore takes priority.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & masks[i*WB_ADDR_W +: WB_ADDR_W]) ==
                bases[i*WB_ADDR_W +: WB_ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/team_06_wb_decoder.sv
// -----------------------------------------------------------------------------
// team_06_wb_decoder
// Single-master to NUM_SLAVES Wishbone address decoder with a slave-wait
// timeout and a sticky error log.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transfer in flight; a master request is decoded here
// BUSY  | request forwarded to one channel, waiting for its ack
// ERR   | one-cycle bus error to the master (no decode hit or timeout)
//
// Ports:
//   wb_clk_i     in   1                    clock, rising edge
//   wb_rst_i     in   1                    asynchronous active-high reset
//   m_cyc_i      in   1                    master cycle
//   m_stb_i      in   1                    master strobe
//   m_we_i       in   1                    master write enable
//   m_adr_i      in   32                   master address
//   m_dat_i      in   32                   master write data
//   m_sel_i      in   4                    master byte selects
//   m_ack_o      out  1                    acknowledge to master
//   m_err_o      out  1                    bus error to master
//   m_dat_o      out  32                   read data to master
//   s_cyc_o      out  NUM_SLAVES           per-channel cycle (one-hot or zero)
//   s_stb_o      out  NUM_SLAVES           per-channel strobe (one-hot or zero)
//   s_we_o       out  1                    registered write enable
//   s_adr_o      out  32                   registered address
//   s_dat_o      out  32                   registered write data
//   s_sel_o      out  4                    registered byte selects
//   s_ack_i      in   NUM_SLAVES           per-channel acknowledge
//   s_dat_i      in   NUM_SLAVES*32        per-channel read data, channel 0 in LSBs
//   err_addr_o   out  32                   address of most recent failed access
//   err_valid_o  out  1                    sticky error flag, cleared by reset
// -----------------------------------------------------------------------------
module team_06_wb_decoder
    import team_06_wb_pkg::*;
#(
    parameter int                            NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*WB_ADDR_W-1:0] SLAVE_BASE   = {32'h3300_0000, 32'h3200_0000,
                                                               32'h3100_0000, 32'h3000_0000},
    parameter logic [NUM_SLAVES*WB_ADDR_W-1:0] SLAVE_MASK   = {4{32'hFF00_0000}},
    parameter int                            TIMEOUT_CYCLES = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,

    input  logic                            m_cyc_i,
    input  logic                            m_stb_i,
    input  logic                            m_we_i,
    input  logic [WB_ADDR_W-1:0]            m_adr_i,
    input  logic [WB_DATA_W-1:0]            m_dat_i,
    input  logic [WB_SEL_W-1:0]             m_sel_i,
    output logic                            m_ack_o,
    output logic                            m_err_o,
    output logic [WB_DATA_W-1:0]            m_dat_o,

    output logic [NUM_SLAVES-1:0]           s_cyc_o,
    output logic [NUM_SLAVES-1:0]           s_stb_o,
    output logic                            s_we_o,
    output logic [WB_ADDR_W-1:0]            s_adr_o,
    output logic [WB_DATA_W-1:0]            s_dat_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    input  logic [NUM_SLAVES-1:0]           s_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_W-1:0] s_dat_i,

    output logic [WB_ADDR_W-1:0]            err_addr_o,
    output logic                            err_valid_o
);

    localparam int                    IDX_W      = idx_width(NUM_SLAVES);
    localparam bit                    TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // The counter starts at 0 in the first BUSY cycle, so the last allowed
    // wait cycle is the one where it holds TIMEOUT_CYCLES-1.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST  = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    dec_state_e              state;
    dec_state_e              state_nxt;

    logic [IDX_W-1:0]        sel_idx;
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    logic                    req;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    sel_ack;
    logic [WB_DATA_W-1:0]    sel_dat;
    logic                    timeout;

    assign req = m_cyc_i & m_stb_i;

    team_06_wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_addr_match (
        .adr   (m_adr_i),
        .bases (SLAVE_BASE),
        .masks (SLAVE_MASK),
        .hit   (hit),
        .idx   (hit_idx)
    );

    // Only the registered channel is looked at; every other ack is ignored.
    // A compare loop avoids indexing past NUM_SLAVES when it is not a power of 2.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ack = s_ack_i[i];
                sel_dat = s_dat_i[i*WB_DATA_W +: WB_DATA_W];
            end
        end
    end

    assign timeout = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // In BUSY an abort beats everything, then an ack beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = hit ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    state_nxt = ST_IDLE;
                end else if (timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Strobes follow the registered state, so they rise one cycle after the
    // request and fall one cycle after ack/abort/timeout, and reset clears
    // them immediately.
    always_comb begin
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_dat_o = '0;
        s_cyc_o = '0;
        s_stb_o = '0;
        case (state)
            ST_BUSY: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    s_cyc_o[i] = (sel_idx == IDX_W'(i));
                    s_stb_o[i] = (sel_idx == IDX_W'(i));
                end
                if (m_cyc_i && sel_ack) begin
                    m_ack_o = 1'b1;
                    m_dat_o = sel_dat;
                end
            end
            ST_ERR: begin
                m_err_o = 1'b1;
                m_dat_o = DEC_ERR_DATA;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    // The request is captured on every IDLE request, including misses, so
    // s_adr_o always holds the address that ERR logs into err_addr_o.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_idx     <= '0;
            wait_cnt    <= '0;
            s_we_o      <= 1'b0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            s_sel_o     <= '0;
            err_addr_o  <= '0;
            err_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (req) begin
                        s_we_o  <= m_we_i;
                        s_adr_o <= m_adr_i;
                        s_dat_o <= m_dat_i;
                        s_sel_o <= m_sel_i;
                        if (hit) begin
                            sel_idx <= hit_idx;
                        end
                    end
                end
                ST_BUSY: begin
                    wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                end
                ST_ERR: begin
                    err_addr_o  <= s_adr_o;
                    err_valid_o <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_06_wb_decoder.sv
module tb_team_06_wb_decoder;

    localparam int NS = 4;
    localparam int TO = 4;
    localparam logic [NS*32-1:0] BASES = {32'h3300_0000, 32'h3200_0000,
                                          32'h3100_0000, 32'h3000_0000};
    localparam logic [NS*32-1:0] MASKS = {4{32'hFF00_0000}};

    logic            clk = 1'b0;
    logic            rst;
    logic            m_cyc, m_stb, m_we;
    logic [31:0]     m_adr, m_wdat;
    logic [3:0]      m_sel;
    logic            m_ack, m_err;
    logic [31:0]     m_rdat;
    logic [NS-1:0]   s_cyc, s_stb;
    logic            s_we;
    logic [31:0]     s_adr, s_wdat;
    logic [3:0]      s_sel;
    logic [NS-1:0]   s_ack;
    logic [NS*32-1:0] s_rdat;
    logic [31:0]     err_addr;
    logic            err_valid;

    always #5 clk = ~clk;

    team_06_wb_decoder #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (BASES),
        .SLAVE_MASK     (MASKS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .m_cyc_i     (m_cyc),
        .m_stb_i     (m_stb),
        .m_we_i      (m_we),
        .m_adr_i     (m_adr),
        .m_dat_i     (m_wdat),
        .m_sel_i     (m_sel),
        .m_ack_o     (m_ack),
        .m_err_o     (m_err),
        .m_dat_o     (m_rdat),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_adr_o     (s_adr),
        .s_dat_o     (s_wdat),
        .s_sel_o     (s_sel),
        .s_ack_i     (s_ack),
        .s_dat_i     (s_rdat),
        .err_addr_o  (err_addr),
        .err_valid_o (err_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ------------------------------------------------------ reference model
    logic [31:0] base_tab [NS] = '{32'h3000_0000, 32'h3100_0000, 32'h3200_0000, 32'h3300_0000};
    logic [31:0] mask_tab [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    logic [31:0] mdl_err_addr  = 32'h0;
    logic        mdl_err_valid = 1'b0;

    function automatic int mdl_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        return -1;
    endfunction

    // Ack or error, counted in cycles after the request edge (1 = first cycle).
    function automatic bit mdl_is_err(input int tgt, input int ack_on);
        return (tgt < 0) || !(ack_on >= 1 && ack_on <= TO);
    endfunction

    function automatic int mdl_event_cycle(input int tgt, input int ack_on);
        if (tgt < 0) return 1;
        if (ack_on >= 1 && ack_on <= TO) return ack_on;
        return TO + 1;
    endfunction

    function automatic logic [3:0] mdl_onehot(input int tgt);
        if (tgt < 0) return 4'b0000;
        return 4'(1 << tgt);
    endfunction

    // ------------------------------------------------- stimulus / observer
    int          ob_ack_cyc, ob_err_cyc;
    logic [31:0] ob_dat_evt, ob_adr, ob_wdat;
    logic [3:0]  ob_stb_first, ob_cyc_first, ob_stb_evt, ob_stb_after, ob_sel;
    logic        ob_we, ob_both, ob_wait_dat_bad, ob_evt_after;

    // Drives one master request and a slave that acks on cycle ack_on
    // (0 = never). noise: 0 none, 1 random acks on other channels, 2 all
    // other channels ack every cycle. Records what the DUT did.
    task automatic drive_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] sel, input int tgt, input int ack_on,
                             input logic [31:0] rd, input int noise);
        logic [NS-1:0] ack_bits;
        ob_ack_cyc = 0; ob_err_cyc = 0; ob_dat_evt = '0; ob_adr = '0; ob_wdat = '0;
        ob_stb_first = '0; ob_cyc_first = '0; ob_stb_evt = '0; ob_stb_after = '1;
        ob_sel = '0; ob_we = 1'b0; ob_both = 1'b0; ob_wait_dat_bad = 1'b0; ob_evt_after = 1'b1;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = a; m_we = we; m_wdat = wd; m_sel = sel;
        s_ack = '0;
        @(posedge clk);
        for (int k = 1; k <= TO + 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (i == tgt)        ack_bits[i] = (k == ack_on);
                else if (noise == 1) ack_bits[i] = 1'($urandom_range(0, 1));
                else if (noise == 2) ack_bits[i] = 1'b1;
                else                 ack_bits[i] = 1'b0;
                s_rdat[i*32 +: 32] = (i == tgt) ? rd : $urandom;
            end
            s_ack = ack_bits;
            #1;
            if (k == 1) begin
                ob_stb_first = s_stb; ob_cyc_first = s_cyc;
                ob_adr = s_adr; ob_wdat = s_wdat; ob_sel = s_sel; ob_we = s_we;
            end
            if (m_ack && m_err) ob_both = 1'b1;
            if (m_ack || m_err) begin
                ob_ack_cyc = m_ack ? k : 0;
                ob_err_cyc = m_err ? k : 0;
                ob_dat_evt = m_rdat;
                ob_stb_evt = s_stb;
                break;
            end
            if (m_rdat != 32'h0) ob_wait_dat_bad = 1'b1;
        end
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
        #1;
        ob_stb_after = s_stb | s_cyc;
        ob_evt_after = m_ack | m_err;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_sel} !== '0) $display("FAIL reset_slave_ctl: got %h expected 0", {s_cyc, s_stb, s_we, s_sel});
        else n_pass++;
        n_checks++;
        if ({s_adr, s_wdat} !== '0) $display("FAIL reset_slave_bus: got %h expected 0", {s_adr, s_wdat});
        else n_pass++;
        n_checks++;
        if ({m_ack, m_err, m_rdat} !== '0) $display("FAIL reset_master: got %h expected 0", {m_ack, m_err, m_rdat});
        else n_pass++;
        n_checks++;
        if ({err_valid, err_addr} !== '0) $display("FAIL reset_errlog: got %h expected 0", {err_valid, err_addr});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({s_stb, m_ack, m_err, err_valid} !== '0) $display("FAIL reset_release_idle: got %h expected 0", {s_stb, m_ack, m_err, err_valid});
        else n_pass++;
    endtask

    task automatic test_write();
        logic [31:0] a = 32'h3000_0010;
        int tgt = mdl_target(a);
        drive_txn(a, 1'b1, 32'hA5A5_A5A5, 4'hF, tgt, 2, 32'h0, 0);
        n_checks++;
        if (ob_stb_first !== mdl_onehot(tgt)) $display("FAIL write_stb: got %b expected %b", ob_stb_first, mdl_onehot(tgt));
        else n_pass++;
        n_checks++;
        if (ob_cyc_first !== mdl_onehot(tgt)) $display("FAIL write_cyc: got %b expected %b", ob_cyc_first, mdl_onehot(tgt));
        else n_pass++;
        n_checks++;
        if ({ob_we, ob_sel, ob_adr, ob_wdat} !== {1'b1, 4'hF, a, 32'hA5A5_A5A5})
            $display("FAIL write_bus: got %h expected %h", {ob_we, ob_sel, ob_adr, ob_wdat}, {1'b1, 4'hF, a, 32'hA5A5_A5A5});
        else n_pass++;
        n_checks++;
        if (ob_ack_cyc !== mdl_event_cycle(tgt, 2)) $display("FAIL write_ack_cycle: got %0d expected %0d", ob_ack_cyc, mdl_event_cycle(tgt, 2));
        else n_pass++;
        n_checks++;
        if (ob_err_cyc !== 0) $display("FAIL write_no_err: got %0d expected 0", ob_err_cyc);
        else n_pass++;
        n_checks++;
        if (ob_stb_after !== 4'b0000) $display("FAIL write_stb_after: got %b expected 0000", ob_stb_after);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] a = 32'h3200_0004;
        int tgt = mdl_target(a);
        drive_txn(a, 1'b0, 32'h0, 4'hF, tgt, 1, 32'h1234_5678, 2);
        n_checks++;
        if (ob_ack_cyc !== 1) $display("FAIL read_ack_cycle: got %0d expected 1", ob_ack_cyc);
        else n_pass++;
        n_checks++;
        if (ob_dat_evt !== 32'h1234_5678) $display("FAIL read_data: got %h expected 12345678", ob_dat_evt);
        else n_pass++;
        n_checks++;
        if (ob_stb_evt !== mdl_onehot(tgt)) $display("FAIL read_stb: got %b expected %b", ob_stb_evt, mdl_onehot(tgt));
        else n_pass++;
        n_checks++;
        if (ob_evt_after !== 1'b0) $display("FAIL read_ack_one_cycle: got %b expected 0", ob_evt_after);
        else n_pass++;
    endtask

    task automatic test_decode_err();
        logic [31:0] a = 32'h4000_0000;
        int tgt = mdl_target(a);
        drive_txn(a, 1'b0, 32'h0, 4'hF, tgt, 1, 32'h0, 1);
        mdl_err_addr = a; mdl_err_valid = 1'b1;
        n_checks++;
        if (ob_err_cyc !== mdl_event_cycle(tgt, 1)) $display("FAIL decerr_cycle: got %0d expected %0d", ob_err_cyc, mdl_event_cycle(tgt, 1));
        else n_pass++;
        n_checks++;
        if (ob_ack_cyc !== 0) $display("FAIL decerr_no_ack: got %0d expected 0", ob_ack_cyc);
        else n_pass++;
        n_checks++;
        if (ob_dat_evt !== 32'hDEAD_BEEF) $display("FAIL decerr_data: got %h expected deadbeef", ob_dat_evt);
        else n_pass++;
        n_checks++;
        if (ob_stb_first !== 4'b0000) $display("FAIL decerr_no_stb: got %b expected 0000", ob_stb_first);
        else n_pass++;
        n_checks++;
        if (ob_evt_after !== 1'b0) $display("FAIL decerr_pulse_width: got %b expected 0", ob_evt_after);
        else n_pass++;
        n_checks++;
        if ({err_valid, err_addr} !== {mdl_err_valid, mdl_err_addr})
            $display("FAIL decerr_log: got %b/%h expected %b/%h", err_valid, err_addr, mdl_err_valid, mdl_err_addr);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] a = 32'h3300_0000 | {8'h0, 24'($urandom)};
        logic [31:0] b = 32'h3300_0000 | {8'h0, 24'($urandom)};
        int tgt = mdl_target(a);
        drive_txn(a, 1'b0, 32'h0, 4'h3, tgt, 0, 32'h0, 1);
        mdl_err_addr = a; mdl_err_valid = 1'b1;
        n_checks++;
        if (ob_err_cyc !== mdl_event_cycle(tgt, 0)) $display("FAIL timeout_cycle: got %0d expected %0d", ob_err_cyc, mdl_event_cycle(tgt, 0));
        else n_pass++;
        n_checks++;
        if (ob_stb_first !== mdl_onehot(tgt)) $display("FAIL timeout_stb_first: got %b expected %b", ob_stb_first, mdl_onehot(tgt));
        else n_pass++;
        n_checks++;
        if (ob_stb_evt !== 4'b0000) $display("FAIL timeout_stb_dropped: got %b expected 0000", ob_stb_evt);
        else n_pass++;
        n_checks++;
        if (ob_wait_dat_bad !== 1'b0) $display("FAIL timeout_wait_data: got %b expected 0", ob_wait_dat_bad);
        else n_pass++;
        n_checks++;
        if (err_addr !== mdl_err_addr) $display("FAIL timeout_err_addr: got %h expected %h", err_addr, mdl_err_addr);
        else n_pass++;
        tgt = mdl_target(b);
        drive_txn(b, 1'b0, 32'h0, 4'hF, tgt, TO, 32'hCAFE_0001, 1);
        n_checks++;
        if (ob_ack_cyc !== mdl_event_cycle(tgt, TO)) $display("FAIL timeout_edge_ack: got %0d expected %0d", ob_ack_cyc, mdl_event_cycle(tgt, TO));
        else n_pass++;
        n_checks++;
        if (ob_err_cyc !== 0) $display("FAIL timeout_edge_no_err: got %0d expected 0", ob_err_cyc);
        else n_pass++;
        n_checks++;
        if (err_addr !== mdl_err_addr) $display("FAIL timeout_edge_log: got %h expected %h", err_addr, mdl_err_addr);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] a = 32'h3100_0020;
        bit seen = 1'b0;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = a; m_we = 1'b1; m_wdat = 32'h1111_2222; m_sel = 4'hF;
        s_ack = '0;
        @(negedge clk);
        #1;
        n_checks++;
        if (s_stb !== mdl_onehot(mdl_target(a))) $display("FAIL abort_stb_up: got %b expected %b", s_stb, mdl_onehot(mdl_target(a)));
        else n_pass++;
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = 4'b0010;
        #1;
        n_checks++;
        if ({m_ack, m_err} !== 2'b00) $display("FAIL abort_no_resp: got %b expected 00", {m_ack, m_err});
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ((s_stb | s_cyc) !== 4'b0000) $display("FAIL abort_stb_drop: got %b expected 0000", s_stb | s_cyc);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (m_ack || m_err) seen = 1'b1;
        end
        s_ack = '0;
        n_checks++;
        if (seen !== 1'b0) $display("FAIL abort_late_resp: got %b expected 0", seen);
        else n_pass++;
        n_checks++;
        if ({err_valid, err_addr} !== {mdl_err_valid, mdl_err_addr})
            $display("FAIL abort_log: got %b/%h expected %b/%h", err_valid, err_addr, mdl_err_valid, mdl_err_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a = 32'h3000_0100;
        bit seen = 1'b0;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = a; m_we = 1'b1; m_wdat = 32'h5555_AAAA; m_sel = 4'hC;
        s_ack = '0;
        @(negedge clk);
        s_ack = 4'b0001;
        s_rdat[31:0] = 32'h7777_8888;
        #1;
        n_checks++;
        if ({s_stb, m_ack} !== {4'b0001, 1'b1}) $display("FAIL rstmid_pre: got %b expected 00011", {s_stb, m_ack});
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        mdl_err_valid = 1'b0; mdl_err_addr = 32'h0;
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_sel, m_ack, m_err} !== '0)
            $display("FAIL rstmid_async_ctl: got %b expected 0", {s_cyc, s_stb, s_we, s_sel, m_ack, m_err});
        else n_pass++;
        n_checks++;
        if ({s_adr, s_wdat, m_rdat, err_addr, err_valid} !== '0)
            $display("FAIL rstmid_async_data: got %h expected 0", {s_adr, s_wdat, m_rdat, err_addr, err_valid});
        else n_pass++;
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (m_ack || m_err || (s_stb != 0)) seen = 1'b1;
        end
        s_ack = '0;
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rstmid_after_release: got %b expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd, rd;
            logic [3:0]  sel;
            logic        we;
            int          r, tgt, ack_on, cyc;
            bit          is_err;
            r = $urandom_range(0, NS);
            if (r < NS) a = base_tab[r] | {8'h0, 24'($urandom)};
            else        a = {8'($urandom_range(8'h40, 8'hFF)), 24'($urandom)};
            ack_on = $urandom_range(0, TO + 1);
            wd = $urandom; rd = $urandom; sel = 4'($urandom); we = 1'($urandom);
            tgt    = mdl_target(a);
            is_err = mdl_is_err(tgt, ack_on);
            cyc    = mdl_event_cycle(tgt, ack_on);
            drive_txn(a, we, wd, sel, tgt, ack_on, rd, 1);
            if (is_err) begin
                mdl_err_addr = a; mdl_err_valid = 1'b1;
            end
            n_checks++;
            if ({ob_ack_cyc, ob_err_cyc} !== {(is_err ? 0 : cyc), (is_err ? cyc : 0)})
                $display("FAIL rand_event[%0d]: got ack %0d err %0d expected ack %0d err %0d", n,
                         ob_ack_cyc, ob_err_cyc, is_err ? 0 : cyc, is_err ? cyc : 0);
            else n_pass++;
            n_checks++;
            if (ob_dat_evt !== (is_err ? 32'hDEAD_BEEF : rd))
                $display("FAIL rand_data[%0d]: got %h expected %h", n, ob_dat_evt, is_err ? 32'hDEAD_BEEF : rd);
            else n_pass++;
            n_checks++;
            if ({ob_stb_first, ob_stb_after, ob_both} !== {mdl_onehot(tgt), 4'b0000, 1'b0})
                $display("FAIL rand_stb[%0d]: got %b/%b/%b expected %b/0000/0", n, ob_stb_first, ob_stb_after, ob_both, mdl_onehot(tgt));
            else n_pass++;
            if (tgt >= 0) begin
                n_checks++;
                if ({ob_we, ob_sel, ob_adr, ob_wdat} !== {we, sel, a, wd})
                    $display("FAIL rand_bus[%0d]: got %h expected %h", n, {ob_we, ob_sel, ob_adr, ob_wdat}, {we, sel, a, wd});
                else n_pass++;
            end
            n_checks++;
            if ({err_valid, err_addr} !== {mdl_err_valid, mdl_err_addr})
                $display("FAIL rand_log[%0d]: got %b/%h expected %b/%h", n, err_valid, err_addr, mdl_err_valid, mdl_err_addr);
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = '0; m_wdat = '0; m_sel = '0;
        s_ack = '0; s_rdat = '0;
        test_reset();
        test_write();
        test_read();
        test_decode_err();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/team_06_wb_decoder.md
TEAM_06_WB_DECODER -- requirements
Module: team_06_wb_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave channels (1..8).
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h3300_0000, 32'h3200_0000, 32'h3100_0000, 32'h3000_0000}, packed NUM_SLAVES x 32 base addresses, channel 0 in LSBs.
REQ-003 SHALL have parameter SLAVE_MASK, default 4 x 32'hFF00_0000, packed NUM_SLAVES x 32 compare masks.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, slave-wait limit; 0 disables the timeout.
REQ-005 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-006 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-007 m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write-enable.
REQ-008 m_adr_i, m_dat_i  in  32 each  master address, write data; m_sel_i  in  4  byte selects.
REQ-009 m_ack_o, m_err_o  out  1 each  master acknowledge, error; m_dat_o  out  32  read data.
REQ-010 s_cyc_o, s_stb_o  out  NUM_SLAVES  per-channel cycle, strobe (one-hot or zero).
REQ-011 s_we_o  out  1; s_adr_o, s_dat_o  out  32; s_sel_o  out  4  registered broadcast copies of master request.
REQ-012 s_ack_i  in  NUM_SLAVES; s_dat_i  in  NUM_SLAVES x 32  per-channel ack and read data.
REQ-013 err_addr_o  out  32  address of most recent failed access; err_valid_o  out  1  sticky error flag.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, ERR.
REQ-015 IDLE: channel i matches when (m_adr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]; lowest matching index SHALL win.
REQ-016 IDLE with m_cyc_i & m_stb_i and a match: SHALL register index, s_adr/s_dat/s_sel/s_we, go BUSY; s_cyc_o/s_stb_o bit asserted from next cycle (1-cycle request latency).
REQ-017 IDLE with m_cyc_i & m_stb_i and no match: SHALL go ERR, no slave strobed.
REQ-018 BUSY: m_ack_o SHALL equal s_ack_i[sel] combinationally, m_dat_o SHALL equal s_dat_i[sel] while ack high, else 0.
REQ-019 BUSY and s_ack_i[sel]: SHALL return to IDLE; s_cyc_o/s_stb_o deasserted the following cycle.
REQ-020 s_ack_i bits of non-selected channels SHALL be ignored at all times.
REQ-021 BUSY: 8-bit wait counter SHALL count from 0 each cycle without ack; on reaching TIMEOUT_CYCLES go ERR, drop slave strobes next cycle.
REQ-022 Ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal ack, no error.
REQ-023 ERR: m_err_o SHALL pulse exactly one cycle, m_dat_o = 32'hDEAD_BEEF, then IDLE; err_addr_o latches registered address, err_valid_o set.
REQ-024 m_cyc_i deasserted in BUSY (abort): SHALL return to IDLE, no m_ack_o/m_err_o, slave strobes dropped next cycle, no error logged.
REQ-025 m_ack_o and m_err_o SHALL never be high in the same cycle.
REQ-026 err_valid_o SHALL clear only on reset; err_addr_o overwritten by each new error.

Reset
REQ-027 On wb_rst_i high, asynchronously: state IDLE, counter 0, all s_cyc_o/s_stb_o 0, s_we_o 0, s_adr_o/s_dat_o 0, s_sel_o 0.
REQ-028 On reset: m_ack_o 0, m_err_o 0, m_dat_o 0, err_addr_o 0, err_valid_o 0.
REQ-029 Reset asserted mid-transaction SHALL drop all slave strobes immediately; no ack or err issued after release.

Structure
REQ-030 Package team_06_wb_pkg SHALL hold the FSM state enum, DEC_ERR_DATA = 32'hDEAD_BEEF, WB_ADDR_W = 32, WB_DATA_W = 32.
REQ-031 Address match/priority logic SHALL be one combinational sub-module team_06_wb_addr_match (inputs address, bases, masks; outputs hit and index).

Verification
REQ-032 Write 0x3000_0010 data 0xA5A5_A5A5 sel 4'hF, slave 0 acks after 2 cycles -> s_stb_o = 4'b0001 one cycle after request, m_ack_o same cycle as s_ack_i[0], strobes low next cycle.
REQ-033 Read 0x3200_0004, slave 2 returns 0x1234_5678 with ack -> m_dat_o = 0x1234_5678 and m_ack_o in that cycle; ack on s_ack_i[1] meanwhile ignored.
REQ-034 Access 0x4000_0000 -> no slave strobe, m_err_o one-cycle pulse, m_dat_o = 0xDEAD_BEEF, err_addr_o = 0x4000_0000, err_valid_o = 1.
REQ-035 TIMEOUT_CYCLES = 4, slave 3 never acks -> m_err_o after 4 BUSY cycles, s_stb_o cleared; repeat with ack on 4th cycle -> m_ack_o, no error.
REQ-036 Master drops m_cyc_i in BUSY -> IDLE, no ack/err, err_valid_o unchanged; wb_rst_i pulse in BUSY -> all outputs 0 asynchronously.
